// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock chain counters.
package clock_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_MODULUS  = 60;
    localparam int MIN_MODULUS  = 60;
    localparam int HOUR_MODULUS = 24;

    // Tens digit of a binary value in 0..99.
    function automatic logic [BCD_W-1:0] bin_to_tens(input int value);
        return BCD_W'(value / 10);
    endfunction

    // Ones digit of a binary value in 0..99.
    function automatic logic [BCD_W-1:0] bin_to_ones(input int value);
        return BCD_W'(value % 10);
    endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control and digit bus of one modulo-N BCD counter stage.
interface bcd_mod_counter_if;
    import clock_pkg::*;

    logic             step;
    logic             down;
    logic             load;
    logic [BCD_W-1:0] load_tens;
    logic [BCD_W-1:0] load_ones;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    logic             carry;
    logic             borrow;
    logic             load_err;

    modport master (
        output step, down, load, load_tens, load_ones,
        input  tens, ones, carry, borrow, load_err
    );

    modport slave (
        input  step, down, load, load_tens, load_ones,
        output tens, ones, carry, borrow, load_err
    );

endinterface

// File: rtl/bcd_mod_counter_digit.sv
// Single 0..9 BCD digit with up/down count, direct set and terminal flags.
module bcd_digit
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_i,
    input  logic [BCD_W-1:0] set_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [BCD_W-1:0] q_o,
    output logic             at_max_o,
    output logic             at_zero_o
);

    logic [BCD_W-1:0] q_d;
    logic [BCD_W-1:0] q_q;

    // Next digit: set wins over increment, increment over decrement; wrap 9<->0.
    always_comb begin
        q_d = q_q;
        if (set_i) begin
            q_d = set_val_i;
        end else if (inc_i) begin
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end else if (dec_i) begin
            q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
        end
    end

    // Digit register with synchronous active-low reset to INIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o       = q_q;
    assign at_max_o  = (q_q == 4'd9);
    assign at_zero_o = (q_q == 4'd0);

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-N up/down counter holding its value natively as two BCD digits,
// with preset, registered carry/borrow pulses and a preset-reject pulse.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MODULUS  = 60,
    parameter int INIT_VAL = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    bcd_mod_counter_if.slave   cnt_if
);

    localparam logic [BCD_W-1:0] INIT_TENS = bin_to_tens(INIT_VAL);
    localparam logic [BCD_W-1:0] INIT_ONES = bin_to_ones(INIT_VAL);
    localparam logic [BCD_W-1:0] MAX_TENS  = bin_to_tens(MODULUS - 1);
    localparam logic [BCD_W-1:0] MAX_ONES  = bin_to_ones(MODULUS - 1);
    localparam logic [7:0]       MOD_8     = 8'(MODULUS);

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS must be in 2..100");
    end
    if (INIT_VAL < 0 || INIT_VAL >= MODULUS) begin : g_bad_init
        $error("bcd_mod_counter: INIT_VAL must be in 0..MODULUS-1");
    end

    logic [BCD_W-1:0] tens_q, ones_q;
    logic             tens_max, tens_zero, ones_max, ones_zero;
    logic             tens_set, ones_set, tens_inc, ones_inc, tens_dec, ones_dec;
    logic [BCD_W-1:0] tens_set_val, ones_set_val;
    logic             value_max, value_zero, load_ok;
    logic [7:0]       load_bin;
    logic             carry_d, borrow_d, err_d;
    logic             carry_q, borrow_q, err_q;

    bcd_digit #(.INIT(INIT_ONES)) u_ones (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_i     (ones_set),
        .set_val_i (ones_set_val),
        .inc_i     (ones_inc),
        .dec_i     (ones_dec),
        .q_o       (ones_q),
        .at_max_o  (ones_max),
        .at_zero_o (ones_zero)
    );

    bcd_digit #(.INIT(INIT_TENS)) u_tens (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_i     (tens_set),
        .set_val_i (tens_set_val),
        .inc_i     (tens_inc),
        .dec_i     (tens_dec),
        .q_o       (tens_q),
        .at_max_o  (tens_max),
        .at_zero_o (tens_zero)
    );

    // Terminal values and preset validation (both digits BCD and value < MODULUS).
    always_comb begin
        if (MODULUS == 100) begin
            value_max = tens_max && ones_max;
        end else begin
            value_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
        end
        value_zero = tens_zero && ones_zero;
        load_bin   = 8'(cnt_if.load_tens) * 8'd10 + 8'(cnt_if.load_ones);
        load_ok    = (cnt_if.load_tens <= 4'd9) && (cnt_if.load_ones <= 4'd9)
                     && (load_bin < MOD_8);
    end

    // Digit control and pulse next-state: load beats step, step beats hold.
    always_comb begin
        tens_set     = 1'b0;
        ones_set     = 1'b0;
        tens_set_val = '0;
        ones_set_val = '0;
        tens_inc     = 1'b0;
        ones_inc     = 1'b0;
        tens_dec     = 1'b0;
        ones_dec     = 1'b0;
        carry_d      = 1'b0;
        borrow_d     = 1'b0;
        err_d        = 1'b0;
        if (cnt_if.load) begin
            if (load_ok) begin
                tens_set     = 1'b1;
                ones_set     = 1'b1;
                tens_set_val = cnt_if.load_tens;
                ones_set_val = cnt_if.load_ones;
            end else begin
                err_d = 1'b1;
            end
        end else if (cnt_if.step) begin
            if (!cnt_if.down) begin
                if (value_max) begin
                    tens_set = 1'b1;
                    ones_set = 1'b1;
                    carry_d  = 1'b1;
                end else begin
                    ones_inc = 1'b1;
                    tens_inc = ones_max;
                end
            end else begin
                if (value_zero) begin
                    tens_set     = 1'b1;
                    ones_set     = 1'b1;
                    tens_set_val = MAX_TENS;
                    ones_set_val = MAX_ONES;
                    borrow_d     = 1'b1;
                end else begin
                    ones_dec = 1'b1;
                    tens_dec = ones_zero;
                end
            end
        end
    end

    // Registered pulses, aligned with the digit update on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign cnt_if.tens     = tens_q;
    assign cnt_if.ones     = ones_q;
    assign cnt_if.carry    = carry_q;
    assign cnt_if.borrow   = borrow_q;
    assign cnt_if.load_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: three instances (mod 60, mod 60 with
// INIT_VAL 58, mod 24) sharing clock and reset.
module tb_bcd_mod_counter;
    import clock_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   carries;
    int   bad_carry;

    always #5 clk = ~clk;

    bcd_mod_counter_if if60 ();
    bcd_mod_counter_if if58 ();
    bcd_mod_counter_if if24 ();

    bcd_mod_counter #(.MODULUS(SEC_MODULUS), .INIT_VAL(0)) dut60 (
        .clk (clk), .reset_n (reset_n), .cnt_if (if60.slave)
    );
    bcd_mod_counter #(.MODULUS(MIN_MODULUS), .INIT_VAL(58)) dut58 (
        .clk (clk), .reset_n (reset_n), .cnt_if (if58.slave)
    );
    bcd_mod_counter #(.MODULUS(HOUR_MODULUS), .INIT_VAL(0)) dut24 (
        .clk (clk), .reset_n (reset_n), .cnt_if (if24.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave the bench 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {if60.step, if60.down, if60.load, if60.load_tens, if60.load_ones} = '0;
        {if58.step, if58.down, if58.load, if58.load_tens, if58.load_ones} = '0;
        {if24.step, if24.down, if24.load, if24.load_tens, if24.load_ones} = '0;
        tick();
        tick();
        check("rst60_val", {if60.tens, if60.ones}, 8'h00);
        check("rst60_pulses", {if60.carry, if60.borrow, if60.load_err}, 3'b000);
        check("rst58_val", {if58.tens, if58.ones}, 8'h58);
        check("rst24_val", {if24.tens, if24.ones}, 8'h00);
        reset_n = 1'b1;

        // Up count through the wrap.
        if60.load = 1'b1; if60.load_tens = 4'd5; if60.load_ones = 4'd8;
        tick();
        check("load58", {if60.tens, if60.ones}, 8'h58);
        if60.load = 1'b0; if60.step = 1'b1; if60.down = 1'b0;
        tick();
        check("up59", {if60.tens, if60.ones, 3'(if60.carry)}, {8'h59, 3'd0});
        tick();
        check("wrap00", {if60.tens, if60.ones, 3'(if60.carry)}, {8'h00, 3'd1});
        tick();
        check("up01", {if60.tens, if60.ones, 3'(if60.carry)}, {8'h01, 3'd0});

        // Down count: 01 -> 00 -> wrap to 59 with borrow.
        if60.down = 1'b1;
        tick();
        check("dn00", {if60.tens, if60.ones, 3'(if60.borrow)}, {8'h00, 3'd0});
        tick();
        check("dnwrap59", {if60.tens, if60.ones, 3'(if60.borrow)}, {8'h59, 3'd1});
        if60.step = 1'b0;
        // Toggling direction without step must not move the value.
        if60.down = 1'b0;
        tick();
        if60.down = 1'b1;
        tick();
        check("nostep_hold", {if60.tens, if60.ones, if60.borrow, if60.carry}, {8'h59, 2'b00});

        // Mod 24 down-wrap and ones borrow into tens.
        if24.load = 1'b1; if24.load_tens = 4'd0; if24.load_ones = 4'd0;
        tick();
        if24.load = 1'b0; if24.step = 1'b1; if24.down = 1'b1;
        tick();
        check("m24_wrap23", {if24.tens, if24.ones, 3'(if24.borrow)}, {8'h23, 3'd1});
        tick();
        check("m24_dn22", {if24.tens, if24.ones, 3'(if24.borrow)}, {8'h22, 3'd0});
        if24.step = 1'b0;

        // Preset validation.
        if24.load = 1'b1; if24.load_tens = 4'd2; if24.load_ones = 4'd4;
        tick();
        check("m24_rej24", {if24.tens, if24.ones, 3'(if24.load_err)}, {8'h22, 3'd1});
        if24.load_tens = 4'd1; if24.load_ones = 4'd10;
        tick();
        check("m24_rej1A", {if24.tens, if24.ones, 3'(if24.load_err)}, {8'h22, 3'd1});
        if24.load_tens = 4'd1; if24.load_ones = 4'd9;
        tick();
        check("m24_acc19", {if24.tens, if24.ones, 3'(if24.load_err)}, {8'h19, 3'd0});
        if24.load = 1'b0; if24.step = 1'b1; if24.down = 1'b0;
        tick();
        check("m24_up20", {if24.tens, if24.ones}, 8'h20);
        if24.down = 1'b1;
        tick();
        check("m24_dn19", {if24.tens, if24.ones}, 8'h19);
        if24.step = 1'b0;
        tick();
        check("m24_err_clear", 32'(if24.load_err), 0);

        // Load beats step in the same cycle, and no carry from the dropped step.
        if60.load = 1'b1; if60.load_tens = 4'd5; if60.load_ones = 4'd9;
        tick();
        if60.load_tens = 4'd3; if60.load_ones = 4'd0;
        if60.step = 1'b1; if60.down = 1'b0;
        tick();
        check("load_over_step", {if60.tens, if60.ones, 3'(if60.carry)}, {8'h30, 3'd0});

        // Held step from 00: one carry every 60 cycles, always showing 00.
        if60.step = 1'b0;
        if60.load_tens = 4'd0; if60.load_ones = 4'd0;
        tick();
        if60.load = 1'b0; if60.step = 1'b1;
        carries = 0;
        bad_carry = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (if60.carry) begin
                carries++;
                if ({if60.tens, if60.ones} != 8'h00 || (i % 60) != 0) bad_carry++;
            end
        end
        check("held_carry_count", carries, 2);
        check("held_carry_place", bad_carry, 0);
        tick();
        tick();
        tick();
        check("held_val03", {if60.tens, if60.ones}, 8'h03);

        // Mid-stream reset; place the counter at 59 so a step would otherwise carry.
        if60.step = 1'b0; if60.load = 1'b1; if60.load_tens = 4'd5; if60.load_ones = 4'd9;
        tick();
        if60.load = 1'b0; if60.step = 1'b1;
        if58.step = 1'b1; if58.down = 1'b0;
        tick();
        check("pre_rst58", {if58.tens, if58.ones, 3'(if58.carry)}, {8'h59, 3'd0});
        if60.load = 1'b1; if60.load_tens = 4'd5; if60.load_ones = 4'd9;
        tick();
        if60.load = 1'b0;
        reset_n = 1'b0;
        tick();
        check("rst_mid60", {if60.tens, if60.ones, 3'(if60.carry)}, {8'h00, 3'd0});
        check("rst_mid58", {if58.tens, if58.ones, 3'(if58.carry)}, {8'h58, 3'd0});
        reset_n = 1'b1;
        tick();
        check("post_rst60", {if60.tens, if60.ones}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised modulo-N counter with direct two-digit BCD outputs. It is the common building block for the seconds, minutes and hours stages of the clock chain: it counts up or down on a single-cycle step input, supports synchronous preset for time-setting, and emits registered carry/borrow pulses to the next stage. It replaces per-stage counters and the divide/modulo BCD conversion; the digits are held natively in BCD.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal range 2..100
INIT_VAL, 0, binary value loaded at reset; must be < MODULUS

Ports:
clk        input   1  system clock, all logic on rising edge
reset_n    input   1  synchronous active-low reset
step       input   1  one-cycle count request (previous stage's carry/borrow, or tick)
down       input   1  direction: 0 = increment, 1 = decrement; sampled with step
load       input   1  synchronous preset strobe
load_tens  input   4  BCD tens digit to preset
load_ones  input   4  BCD ones digit to preset
tens       output  4  current value, BCD tens
ones       output  4  current value, BCD ones
carry      output  1  one-cycle pulse on up-wrap MODULUS-1 -> 0
borrow     output  1  one-cycle pulse on down-wrap 0 -> MODULUS-1
load_err   output  1  one-cycle pulse when a preset is rejected

Behaviour:
- Reset: synchronous, active-low, on the clk edge with reset_n=0. tens/ones = BCD of INIT_VAL; carry, borrow and load_err = 0. Reset has priority over every other input.
- Priority when reset_n=1: load > step > hold.
- Load: value V = 10*load_tens + load_ones. Accept only if both digits ≤ 9 and V < MODULUS. On accept, the next edge updates tens/ones to the preset digits. On reject, the value is held and load_err = 1 for one cycle. carry and borrow are 0 in any load cycle, and any step in that cycle is dropped.
- Step up (step=1, down=0):
  - ones<9 and value≠MODULUS-1: ones+1.
  - ones=9: ones=0, tens+1.
  - value = MODULUS-1: tens=ones=0, carry=1.
- Step down (step=1, down=1):
  - ones>0: ones-1.
  - ones=0 and value≠0: ones=9, tens-1.
  - value=0: digits = BCD of MODULUS-1, borrow=1.
- Latency: one cycle. The output digits and the carry/borrow pulse change on the same edge, so carry is high in the first cycle that shows 00. This allows chained stages to feed carry directly into the next step.
- carry, borrow and load_err are registered. Each is 0 in every cycle not described above; a held step never produces more than one pulse per step cycle.
- step held high for N cycles produces N counts. Back-to-back wraps are legal, e.g. MODULUS=2 gives a carry every other cycle.
- Direction is sampled only when step=1; toggling down without step has no effect.
- MODULUS=100: wrap from 99; tens reaches 9. MODULUS<10: tens stays 0.
- Value always remains < MODULUS and both digits ≤ 9. No illegal state is reachable.
- Elaboration checks: MODULUS outside 2..100, or INIT_VAL ≥ MODULUS, is an elaboration error.

Decomposition:
- Shared package clock_pkg holds:
  - constants SEC_MODULUS=60, MIN_MODULUS=60, HOUR_MODULUS=24
  - BCD_W=4
  - helper functions to convert a binary value to BCD tens/ones, used to derive the reset and wrap digit constants at elaboration.
- Natural sub-module: bcd_digit, a single 0..9 up/down digit with terminal-count flags (at_max, at_zero).
- bcd_mod_counter instantiates two bcd_digit stages plus the modulus-compare, load-validate and pulse logic.

Test Plan:
- MODULUS=60, reset_n=0 for 2 cycles, then 1 -> tens=0, ones=0; all pulses 0. With INIT_VAL=58, digits read 5/8.
- MODULUS=60, load 5/8, then 3 up steps -> 59, then 00 with carry=1 in that same cycle, then 01 with carry=0.
- MODULUS=24, load 0/0, down step -> 2/3 with borrow=1; a further down step -> 2/2 with borrow=0.
- MODULUS=24: load 2/4 -> load_err=1, value unchanged. Load 1/10 (invalid BCD) -> load_err=1. Load 1/9 -> value 19, load_err=0.
- MODULUS=60, value 59, load=1 and step=1 in the same cycle with load 3/0 -> value 30, carry=0.
- MODULUS=60, step held high continuously from 00 -> exactly one carry every 60 cycles. Asserting reset_n=0 mid-stream returns the value to INIT_VAL on that edge, with carry=0.
